// File: rtl/dmem_arbiter.sv
// Data-SRAM port 0 arbiter: the core has fixed priority with zero added latency; loader writes are
// queued in a small FIFO and drained on idle cycles. Define DMEM_ARB_STARVE_EN for a forced steal.
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 13,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  core_csb_i,
    input  logic                  core_web_i,
    input  logic [3:0]            core_wmask_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic [31:0]           core_data_i,
    output logic [31:0]           core_rdata_o,
    output logic                  core_rvalid_o,
    output logic                  core_stall_o,
    input  logic                  ldr_req_i,
    input  logic [ADDR_WIDTH-1:0] ldr_addr_i,
    input  logic [31:0]           ldr_data_i,
    input  logic [3:0]            ldr_wmask_i,
    output logic                  ldr_ready_o,
    output logic                  ldr_busy_o,
    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic [3:0]            sram_wmask_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_din_o,
    input  logic [31:0]           sram_dout_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("dmem_arbiter: FIFO_DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
    end

    logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [31:0]           data_mem [FIFO_DEPTH];
    logic [3:0]            mask_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             rvalid_reg;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic steal;
    logic core_gnt;
    logic ldr_gnt;

    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign push       = ldr_req_i & ~fifo_full;

`ifdef DMEM_ARB_STARVE_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_cnt_reg;

    assign steal = ~fifo_empty & (starve_cnt_reg == STARVE_W'(STARVE_LIMIT));

    // Counts only cycles where the queue is blocked by the core; any pop restarts the wait.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            starve_cnt_reg <= '0;
        end else if (pop) begin
            starve_cnt_reg <= '0;
        end else if (!fifo_empty && core_gnt) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end
`else
    assign steal = 1'b0;
`endif

    // The port is forced idle while reset is held, even if the core is selecting it.
    assign core_gnt = reset_i & ~core_csb_i & ~steal;
    assign ldr_gnt  = reset_i & ~core_gnt & ~fifo_empty;
    assign pop      = ldr_gnt;

    always_comb begin
        sram_csb_o   = 1'b1;
        sram_web_o   = 1'b1;
        sram_wmask_o = '0;
        sram_addr_o  = '0;
        sram_din_o   = '0;
        if (core_gnt) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = core_web_i;
            sram_wmask_o = core_wmask_i;
            sram_addr_o  = core_addr_i;
            sram_din_o   = core_data_i;
        end else if (ldr_gnt) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = 1'b0;
            sram_wmask_o = mask_mem[rd_ptr_reg];
            sram_addr_o  = addr_mem[rd_ptr_reg];
            sram_din_o   = data_mem[rd_ptr_reg];
        end
    end

    // Entry storage needs no reset: only the pointers and count decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= ldr_addr_i;
            data_mem[wr_ptr_reg] <= ldr_data_i;
            mask_mem[wr_ptr_reg] <= ldr_wmask_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg  <= count_reg + CNT_W'(push) - CNT_W'(pop);
            rvalid_reg <= core_gnt & core_web_i;
        end
    end

    assign core_rdata_o  = sram_dout_i;
    assign core_rvalid_o = rvalid_reg;
    assign core_stall_o  = steal;
    assign ldr_ready_o   = ~fifo_full;
    assign ldr_busy_o    = ~fifo_empty | ldr_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a queue-based reference model predicts every SRAM access and
// per-cycle status; a negedge monitor compares them against the DUT.
module tb_dmem_arbiter;

    localparam int AW    = 13;
    localparam int DEPTH = 4;
    localparam int LIMIT = 16;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          core_csb_i, core_web_i;
    logic [3:0]    core_wmask_i;
    logic [AW-1:0] core_addr_i;
    logic [31:0]   core_data_i;
    logic [31:0]   core_rdata_o;
    logic          core_rvalid_o, core_stall_o;
    logic          ldr_req_i;
    logic [AW-1:0] ldr_addr_i;
    logic [31:0]   ldr_data_i;
    logic [3:0]    ldr_wmask_i;
    logic          ldr_ready_o, ldr_busy_o;
    logic          sram_csb_o, sram_web_o;
    logic [3:0]    sram_wmask_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_din_o;
    logic [31:0]   sram_dout_i;

    dmem_arbiter #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .core_csb_i(core_csb_i), .core_web_i(core_web_i), .core_wmask_i(core_wmask_i),
        .core_addr_i(core_addr_i), .core_data_i(core_data_i),
        .core_rdata_o(core_rdata_o), .core_rvalid_o(core_rvalid_o), .core_stall_o(core_stall_o),
        .ldr_req_i(ldr_req_i), .ldr_addr_i(ldr_addr_i), .ldr_data_i(ldr_data_i),
        .ldr_wmask_i(ldr_wmask_i), .ldr_ready_o(ldr_ready_o), .ldr_busy_o(ldr_busy_o),
        .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o), .sram_wmask_o(sram_wmask_o),
        .sram_addr_o(sram_addr_o), .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    mask;
    } ent_t;

    typedef struct packed {
        logic          web;
        logic [3:0]    mask;
        logic [AW-1:0] addr;
        logic [31:0]   din;
    } txn_t;

    typedef struct packed {
        logic        csb;
        logic        ready;
        logic        busy;
        logic        rvalid;
        logic        stall;
        logic [31:0] rdata;
    } stat_t;

    txn_t  txn_q[$];
    stat_t stat_q[$];
    ent_t  m_q[$];
    int    m_wait   = 0;
    logic  m_rvalid = 1'b0;
    int    checks   = 0;
    int    errors   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: apply inputs, let the model predict this cycle, then advance the model.
    task automatic drive(input logic rst, input logic c_req, input logic c_we, input logic l_req,
                         input logic [AW-1:0] l_addr, input logic [31:0] l_data, input logic [3:0] l_mask);
        stat_t s;
        txn_t  t;
        ent_t  e;
        logic  steal, core_g, ldr_g;
        reset_i      = rst;
        core_csb_i   = ~c_req;
        core_web_i   = ~c_we;
        core_wmask_i = 4'($urandom);
        core_addr_i  = AW'($urandom);
        core_data_i  = $urandom;
        ldr_req_i    = l_req;
        ldr_addr_i   = l_addr;
        ldr_data_i   = l_data;
        ldr_wmask_i  = l_mask;
        sram_dout_i  = $urandom;
        s.rdata      = sram_dout_i;
        if (!rst) begin
            m_q.delete();
            m_wait   = 0;
            m_rvalid = 1'b0;
            s.csb = 1'b1; s.ready = 1'b1; s.busy = 1'b0; s.rvalid = 1'b0; s.stall = 1'b0;
            stat_q.push_back(s);
        end else begin
            steal  = STARVE_ON && m_q.size() != 0 && m_wait == LIMIT;
            core_g = c_req && !steal;
            ldr_g  = !core_g && m_q.size() != 0;
            s.csb    = !(core_g || ldr_g);
            s.ready  = m_q.size() < DEPTH;
            s.busy   = m_q.size() != 0;
            s.rvalid = m_rvalid;
            s.stall  = steal;
            stat_q.push_back(s);
            if (core_g) begin
                t = '{web: ~c_we, mask: core_wmask_i, addr: core_addr_i, din: core_data_i};
                txn_q.push_back(t);
            end
            if (ldr_g) begin
                e = m_q.pop_front();
                t = '{web: 1'b0, mask: e.mask, addr: e.addr, din: e.data};
                txn_q.push_back(t);
                m_wait = 0;
            end else if (m_q.size() != 0 && core_g) begin
                m_wait++;
            end
            if (l_req && s.ready) m_q.push_back('{addr: l_addr, data: l_data, mask: l_mask});
            m_rvalid = core_g && !c_we;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic rnd(input logic rst, input logic c_req, input logic l_req);
        drive(rst, c_req, 1'($urandom), l_req, AW'($urandom), $urandom, 4'($urandom));
    endtask

    // Monitor: every cycle's status, plus one scoreboard pop per SRAM access the DUT presents.
    always @(negedge clk_i) begin
        stat_t s;
        txn_t  t;
        if (stat_q.size() != 0) begin
            s = stat_q.pop_front();
            chk("sram_csb", 64'(sram_csb_o), 64'(s.csb));
            chk("ldr_ready", 64'(ldr_ready_o), 64'(s.ready));
            chk("ldr_busy", 64'(ldr_busy_o), 64'(s.busy));
            chk("core_rvalid", 64'(core_rvalid_o), 64'(s.rvalid));
            chk("core_stall", 64'(core_stall_o), 64'(s.stall));
            chk("core_rdata", 64'(core_rdata_o), 64'(s.rdata));
        end
        if (sram_csb_o === 1'b0) begin
            $display("txn t=%0t web=%0b addr=%h din=%h mask=%h", $time, sram_web_o, sram_addr_o,
                     sram_din_o, sram_wmask_o);
            if (txn_q.size() == 0) begin
                chk("unexpected_sram_access", 64'(1), 64'(0));
            end else begin
                t = txn_q.pop_front();
                chk("sram_access", {sram_web_o, sram_wmask_o, sram_addr_o, sram_din_o},
                    64'({t.web, t.mask, t.addr, t.din}));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i = 1'b0; core_csb_i = 1'b1; core_web_i = 1'b1; core_wmask_i = '0;
        core_addr_i = '0; core_data_i = '0; ldr_req_i = 1'b0; ldr_addr_i = '0;
        ldr_data_i = '0; ldr_wmask_i = '0; sram_dout_i = '0;
        @(posedge clk_i);
        #1;
        // Reset held with the core selecting: port must stay idle.
        repeat (3) rnd(1'b0, 1'b1, 1'b1);

        // Single loader write with an idle core.
        drive(1'b1, 1'b0, 1'b0, 1'b1, AW'('h0010), 32'hDEADBEEF, 4'hF);
        repeat (3) rnd(1'b1, 1'b0, 1'b0);

        // Fill the FIFO behind a busy core, try extra pushes, then drain.
        repeat (7) rnd(1'b1, 1'b1, 1'b1);
        repeat (6) rnd(1'b1, 1'b0, 1'b0);

        // Core reads while two entries wait, then idle cycles to drain.
        repeat (2) rnd(1'b1, 1'b1, 1'b1);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, AW'('h0100), $urandom, 4'($urandom));
        repeat (4) rnd(1'b1, 1'b0, 1'b0);

        // Push and pop together at count 2 and at full.
        repeat (2) rnd(1'b1, 1'b1, 1'b1);
        repeat (3) rnd(1'b1, 1'b0, 1'b1);
        repeat (2) rnd(1'b1, 1'b1, 1'b1);
        repeat (3) rnd(1'b1, 1'b0, 1'b1);
        repeat (6) rnd(1'b1, 1'b0, 1'b0);

        // Reset in the middle of a three-write burst behind a busy core.
        repeat (2) rnd(1'b1, 1'b1, 1'b1);
        rnd(1'b0, 1'b1, 1'b1);
        repeat (4) rnd(1'b1, 1'b0, 1'b0);

        // One entry waiting behind a continuously busy core.
        rnd(1'b1, 1'b1, 1'b1);
        repeat (40) rnd(1'b1, 1'b1, 1'b0);
        repeat (3) rnd(1'b1, 1'b0, 1'b0);

        // Random blocks with varying core and loader load, occasional reset.
        for (int blk = 0; blk < 12; blk++) begin
            int pc, pl;
            pc = int'($urandom_range(0, 100));
            pl = int'($urandom_range(0, 100));
            for (int c = 0; c < 50; c++) begin
                rnd(($urandom_range(0, 199) != 0), (int'($urandom_range(0, 99)) < pc),
                    (int'($urandom_range(0, 99)) < pl));
            end
        end

        repeat (10) rnd(1'b1, 1'b0, 1'b0);
        chk("scoreboard_drained", 64'(txn_q.size()), 64'(0));
        chk("model_fifo_drained", 64'(m_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
